wb_master_bridge: RTL and testbench

Single-master WISHBONE classic-cycle bridge between the MIPS core's MEM stage and the slave address decoder / ack multiplexer. Converts a CPU load/store request into one WISHBONE read or write cycle and holds the pipeline with `pause` until the cycle terminates. It drives the shared address, data and select lines that the slave-select decode consumes. It returns registered read data to the write-back path.

---
 rtl/wb_master_bridge.sv | 140 ++++++++++++++
 tb/tb_wb_master_bridge.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_master_bridge.sv
// wb_master_bridge: single-master WISHBONE classic-cycle bridge between the
// MEM stage and the slave decoder. Each CPU load/store becomes one bus cycle.
// The pipeline is held with `pause` until that cycle terminates.
// Optional feature: define WB_TIMEOUT_EN to abort cycles that receive no
// ack/err within TIMEOUT bus cycles. The abort is reported as a bus error.
module wb_master_bridge #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    // MEM-stage side
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_be,
    output logic [31:0] cpu_rdata,
    output logic        pause,
    output logic        bus_err,
    // WISHBONE master side
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic accept;    // request taken this cycle
    logic tmo_hit;   // timeout reached in the current BUS cycle
    logic term_err;  // cycle ends as an error (err, or timeout without ack)
    logic term_any;  // cycle ends this clock

    // The timeout limit must fit the 16-bit counter.
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("wb_master_bridge: TIMEOUT must be in 1..65535");
    end

    assign accept   = (state_q == S_IDLE) && cpu_req;
    assign term_err = (state_q == S_BUS) && (wb_err_i || (tmo_hit && !wb_ack_i));
    assign term_any = (state_q == S_BUS) && (wb_ack_i || wb_err_i || tmo_hit);

`ifdef WB_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    logic [15:0] tmo_cnt;

    // Count BUS cycles; the count is 0 in the first BUS cycle, so the
    // TIMEOUT-th BUS cycle is the one where the count equals TIMEOUT-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (accept) begin
            tmo_cnt <= '0;
        end else if (state_q == S_BUS) begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end

    assign tmo_hit = (state_q == S_BUS) && (tmo_cnt == TMO_LAST);
`else
    assign tmo_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first, so no path leaves state_d unassigned
        // and no latch is inferred.
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cpu_req)  state_d = S_BUS;
            S_BUS:   if (term_any) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;   // cpu_req still belongs to the finished access
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: cyc/stb follow the registered state, so an asynchronous
    // reset drops them immediately.
    always_comb begin
        wb_cyc_o = (state_q == S_BUS);
        wb_stb_o = (state_q == S_BUS);
        pause    = accept || (state_q == S_BUS);
    end

    // Latch the request into the bus output registers when it is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: these are plain output registers, not storage arrays, so they
        // get reset values and the bus never shows X after reset.
        if (!rst_n) begin
            wb_we_o  <= 1'b0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            wb_sel_o <= '0;
        end else if (accept) begin
            wb_we_o  <= cpu_we;
            wb_adr_o <= cpu_addr;
            wb_dat_o <= cpu_wdata;
            wb_sel_o <= cpu_be;
        end
    end

    // Capture read data on termination, and flag errors with a one-cycle
    // pulse that lands in DONE. Stores never touch cpu_rdata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rdata <= '0;
            bus_err   <= 1'b0;
        end else begin
            bus_err <= term_err;
            if (term_any && !wb_we_o) begin
                cpu_rdata <= term_err ? 32'h0 : wb_dat_i;
            end
        end
    end

endmodule

// File: tb/tb_wb_master_bridge.sv
// Self-checking bench for wb_master_bridge: directed cases plus randomized
// load/store traffic with random wait states, errors and stray terminations.
// Expected values come from a transaction-level model of the bridge.
// Build with WB_TIMEOUT_EN defined to add the timeout cases.
module tb_wb_master_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_rdata;
    logic        pause, bus_err;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i, wb_err_i;

    wb_master_bridge #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_be    (cpu_be),
        .cpu_rdata (cpu_rdata),
        .pause     (pause),
        .bus_err   (bus_err),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_we_o   (wb_we_o),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_sel_o  (wb_sel_o),
        .wb_dat_i  (wb_dat_i),
        .wb_ack_i  (wb_ack_i),
        .wb_err_i  (wb_err_i)
    );

    always #5 clk = ~clk;

    // Termination kinds presented by the bench slave.
    localparam int K_ACK = 0, K_ERR = 1, K_BOTH = 2, K_NONE = 3;

    int n_checks = 0;
    int n_pass   = 0;
    int n_cyc    = 0;   // bus cycles observed on wb_cyc_o
    int n_issued = 0;   // bus cycles the model expects

    logic [31:0] exp_rdata;   // model: last completed load value

    always @(posedge wb_cyc_o) n_cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cycstb"}, {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
        check({tag, "_we"},     {31'd0, wb_we_o}, 32'd0);
        check({tag, "_adr"},    wb_adr_o, 32'd0);
        check({tag, "_dat"},    wb_dat_o, 32'd0);
        check({tag, "_sel"},    {28'd0, wb_sel_o}, 32'd0);
        check({tag, "_rdata"},  cpu_rdata, 32'd0);
        check({tag, "_err"},    {31'd0, bus_err}, 32'd0);
    endtask

    // One idle cycle with no request; stray terminations must be ignored.
    task automatic idle_cycle();
        @(negedge clk);
        cpu_req  = 1'b0;
        wb_ack_i = 1'($urandom);
        wb_err_i = 1'($urandom);
        wb_dat_i = $urandom;
        #1;
        check("idle_pause", {31'd0, pause}, 32'd0);
        check("idle_cyc",   {31'd0, wb_cyc_o}, 32'd0);
        check("idle_err",   {31'd0, bus_err}, 32'd0);
        check("idle_rdata", cpu_rdata, exp_rdata);
    endtask

    // One complete access: request cycle, waits+1 BUS cycles, DONE cycle.
    // 'hold' keeps cpu_req high through DONE (back-to-back traffic).
    task automatic access(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                          input logic [3:0] be, input int waits, input int kind,
                          input logic [31:0] rd, input logic hold);
        logic is_err;
        is_err = (kind != K_ACK);
        // request cycle (IDLE)
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = adr; cpu_wdata = wdat; cpu_be = be;
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = $urandom;
        #1;
        check("req_pause", {31'd0, pause}, 32'd1);
        check("req_cyc",   {31'd0, wb_cyc_o}, 32'd0);
        check("req_err",   {31'd0, bus_err}, 32'd0);
        check("req_rdata", cpu_rdata, exp_rdata);
        // BUS cycles
        for (int i = 0; i <= waits; i++) begin
            @(negedge clk);
            if (i == waits) begin
                wb_ack_i = (kind == K_ACK) || (kind == K_BOTH);
                wb_err_i = (kind == K_ERR) || (kind == K_BOTH);
                wb_dat_i = rd;
            end else begin
                wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = $urandom;
            end
            #1;
            check("bus_cycstb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd3);
            check("bus_we",     {31'd0, wb_we_o}, {31'd0, we});
            check("bus_adr",    wb_adr_o, adr);
            check("bus_dat",    wb_dat_o, wdat);
            check("bus_sel",    {28'd0, wb_sel_o}, {28'd0, be});
            check("bus_pause",  {31'd0, pause}, 32'd1);
            check("bus_rdata",  cpu_rdata, exp_rdata);
        end
        n_issued++;
        if (!we) exp_rdata = is_err ? 32'h0 : rd;
        // DONE cycle: stray terminations and a held request are both ignored
        @(negedge clk);
        cpu_req  = hold;
        wb_ack_i = 1'($urandom);
        wb_err_i = 1'($urandom);
        wb_dat_i = $urandom;
        #1;
        check("done_cycstb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
        check("done_pause",  {31'd0, pause}, 32'd0);
        check("done_err",    {31'd0, bus_err}, {31'd0, is_err});
        check("done_rdata",  cpu_rdata, exp_rdata);
    endtask

    initial begin
        rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        cpu_be = '0; wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
        exp_rdata = 32'h0;
        #12;
        check_reset_outputs("rst");
        check("rst_pause", {31'd0, pause}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero-wait load.
        access(1'b0, 32'h8000_0010, 32'h0, 4'hF, 0, K_ACK, 32'h1234_5678, 1'b0);
        idle_cycle();
        // Store with 3 wait states; read data must not move.
        access(1'b1, 32'h0000_0100, 32'hCAFE_F00D, 4'b0011, 3, K_ACK, 32'hDEAD_BEEF, 1'b0);
        idle_cycle();
        // Err together with ack on a load: err wins.
        access(1'b0, 32'h0000_0200, 32'h0, 4'hF, 1, K_BOTH, 32'h5555_AAAA, 1'b0);
        // Back-to-back loads with cpu_req held through DONE.
        access(1'b0, 32'h0000_0300, 32'h0, 4'hF, 0, K_ACK, 32'h0BAD_F00D, 1'b1);
        access(1'b0, 32'h0000_0304, 32'h0, 4'hF, 0, K_ACK, 32'h1357_9BDF, 1'b0);
        // Zero byte enables still produce a bus cycle.
        access(1'b1, 32'h0000_0400, 32'h1111_2222, 4'b0000, 0, K_ACK, 32'h0, 1'b0);
        idle_cycle();

        // Reset during a BUS wait: cyc/stb and pause drop without a clock edge.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'hA5A5_0000; cpu_wdata = 32'h0F0F_0F0F;
        cpu_be = 4'hF; wb_ack_i = 1'b0; wb_err_i = 1'b0;
        @(negedge clk);
        check("pre_rst_cyc", {31'd0, wb_cyc_o}, 32'd1);
        n_issued++;
        #2;
        rst_n = 1'b0; cpu_req = 1'b0;
        #1;
        check_reset_outputs("midrst");
        check("midrst_pause", {31'd0, pause}, 32'd0);
        exp_rdata = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        access(1'b0, 32'h0000_0500, 32'h0, 4'hF, 1, K_ACK, 32'h7777_8888, 1'b0);

`ifdef WB_TIMEOUT_EN
        // No termination: abort after 4 BUS cycles as an error.
        access(1'b0, 32'h0000_0600, 32'h0, 4'hF, 3, K_NONE, 32'h0, 1'b0);
        idle_cycle();
        // Ack in the timeout cycle takes priority.
        access(1'b0, 32'h0000_0604, 32'h0, 4'hF, 3, K_ACK, 32'h2468_ACE0, 1'b0);
        idle_cycle();
`endif

        // Randomized traffic; errors only on loads, at most 2 wait states.
        for (int t = 0; t < 40; t++) begin
            logic        we;
            int          kind;
            we   = 1'($urandom);
            kind = we ? K_ACK : (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : K_ACK);
            access(we, $urandom, $urandom, 4'($urandom), int'($urandom_range(0, 2)),
                   kind, $urandom, 1'($urandom));
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) idle_cycle();
        end
        idle_cycle();

        check("bus_cycle_count", 32'(n_cyc), 32'(n_issued));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
